// File: rtl/mcu32x_pkg.sv
// Shared MCU32X definitions: bus widths and the memory arbiter state encoding.
package mcu32x_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and shared memory port of the MCU32X memory arbiter.
// The master modport is the arbiter's view; slave is the requesters plus memory.
interface mem_arbiter_if;
    import mcu32x_pkg::*;

    logic              if_req;
    logic              if_gnt;
    logic              if_done;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic              d_gnt;
    logic              d_done;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_ready;

    logic              bus_err;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data, mem_ready,
        output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
        output mem_address, mem_write_data, mem_read, mem_write, bus_err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data, mem_ready,
        input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
        input  mem_address, mem_write_data, mem_read, mem_write, bus_err
    );

endinterface

// File: rtl/mem_arbiter_timer.sv
// arb_timer: 16-bit BUSY watchdog. expired is high in the BUSY cycle whose
// increment brings the count to TIMEOUT, so the abort lands on that same edge.
module arb_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] count;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset)       count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 16'd1;
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a fetch and a data requester.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is data-first priority.
module mem_arbiter
    import mcu32x_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    arb_state_t        state, state_next;
    logic              pick_d, grant_i, grant_d;
    logic              busy, expired, finish;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, if_rdata_q, d_rdata_q;
    logic              if_done_q, d_done_q, err_q;

`ifdef MEM_ARB_RR_EN
    logic last_d;  // 1: the data port won the most recent grant

    assign pick_d = bus.d_req && !(bus.if_req && last_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   last_d <= 1'b0;
        else if (grant_i || grant_d) last_d <= grant_d;
    end
`else
    assign pick_d = bus.d_req;
`endif

    assign busy   = (state != IDLE);
    assign finish = busy && (bus.mem_ready || expired);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (pick_d) begin
                        grant_d    = 1'b1;
                        state_next = BUSY_D;
                    end else if (bus.if_req) begin
                        grant_i    = 1'b1;
                        state_next = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: if (finish) state_next = IDLE;
            default:        state_next = IDLE;
        endcase
    end

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (grant_i || grant_d),
        .enable  (busy && !bus.mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state     <= state_next;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
            if (grant_d) begin
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
                we_q    <= bus.d_we;
            end else if (grant_i) begin
                addr_q <= bus.if_addr;
                we_q   <= 1'b0;
            end
            // A timed-out read returns zero; write completions leave d_rdata untouched.
            if (finish) begin
                err_q <= !bus.mem_ready;
                if (state == BUSY_I) begin
                    if_done_q  <= 1'b1;
                    if_rdata_q <= bus.mem_ready ? bus.mem_read_data : '0;
                end else begin
                    d_done_q <= 1'b1;
                    if (!we_q) d_rdata_q <= bus.mem_ready ? bus.mem_read_data : '0;
                end
            end
        end
    end

    assign bus.if_gnt         = grant_i;
    assign bus.d_gnt          = grant_d;
    assign bus.if_done        = if_done_q;
    assign bus.d_done         = d_done_q;
    assign bus.if_rdata       = if_rdata_q;
    assign bus.d_rdata        = d_rdata_q;
    assign bus.bus_err        = err_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.mem_read       = (state == BUSY_I) || ((state == BUSY_D) && !we_q);
    assign bus.mem_write      = (state == BUSY_D) && we_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUSY cycles before an access is aborted (legal range 1..65535).
REQ-002 SHALL have clk, input, 1, rising-edge clock.
REQ-003 SHALL have reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have if_req/if_gnt/if_done, input/output/output, 1 each, fetch-port request, one-cycle accept pulse and one-cycle completion pulse.
REQ-005 SHALL have if_addr input 32 and if_rdata output 32, fetch address and read data.
REQ-006 SHALL have d_req/d_we/d_gnt/d_done, input/input/output/output, 1 each, data-port request, write-enable, accept pulse and completion pulse.
REQ-007 SHALL have d_addr input 32, d_wdata input 32 and d_rdata output 32, data address, write data and read data.
REQ-008 SHALL have mem_address output 32, mem_write_data output 32, mem_read output 1, mem_write output 1, mem_read_data input 32 and mem_ready input 1, the shared memory port.
REQ-009 SHALL have bus_err, output, 1, high together with the done pulse of a timed-out access.

Function
REQ-010 SHALL implement the states IDLE, BUSY_I and BUSY_D.
REQ-011 IDLE: if any request is present, SHALL assert the winner's gnt combinationally in that cycle, latch its addr/wdata/we, and enter BUSY_I or BUSY_D at the next edge.
REQ-012 Priority without the macro: data port SHALL win over fetch whenever both request in the same IDLE cycle.
REQ-013 In BUSY, SHALL drive mem_address and mem_write_data from the latched copies, held stable for the entire access.
REQ-014 In BUSY, SHALL assert mem_read for BUSY_I or for BUSY_D with we=0, and mem_write for BUSY_D with we=1.
REQ-015 mem_read and mem_write SHALL never be high together, and both SHALL be 0 in IDLE.
REQ-016 On a BUSY cycle with mem_ready=1, SHALL register mem_read_data into the owner's rdata (reads only) and pulse the owner's done for the next cycle.
REQ-017 After REQ-016, SHALL return to IDLE in the same cycle done is high, so a new grant is possible in that cycle (back-to-back throughput of one access per 2+ cycles).
REQ-018 Minimum latency SHALL be gnt in cycle 0, memory strobe in cycle 1, mem_ready in cycle 1, done with data in cycle 2.
REQ-019 d_rdata SHALL retain its previous value on write completions; if_rdata/d_rdata SHALL change only at their own done.
REQ-020 A 16-bit timeout counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready.
REQ-021 When the counter reaches TIMEOUT, SHALL abort: pulse owner's done with bus_err=1, load rdata with 0 for reads, and return to IDLE.
REQ-022 A req deasserted while its access is BUSY SHALL be ignored; the access SHALL complete normally.
REQ-023 A requester SHALL get no gnt while the arbiter is BUSY; requests SHALL be evaluated only in IDLE.

Reset
REQ-024 On reset, SHALL force state IDLE and set all gnt, done, bus_err, mem_read and mem_write to 0.
REQ-025 On reset, SHALL clear mem_address, mem_write_data, if_rdata, d_rdata, the counter and the last-grant flag to 0.
REQ-026 Reset mid-access SHALL drop the transaction with no done pulse.

Configuration
REQ-027 With MEM_ARB_RR_EN defined, simultaneous requests SHALL go to the port not granted most recently; the last-grant flag resets to "fetch", so data wins the first tie.
REQ-028 Without MEM_ARB_RR_EN, SHALL use the fixed priority of REQ-012 and SHALL contain no last-grant flag.

Structure
REQ-029 The shared package mcu32x_pkg SHALL hold the arb_state_t enum (IDLE, BUSY_I, BUSY_D) and the ADDR_W=32 and DATA_W=32 constants.
REQ-030 The timeout counter SHALL be the single sub-module arb_timer (inputs clear/enable, output expired), parameterised by TIMEOUT.

Verification
REQ-031 Fetch-only read of if_addr=0x100 with mem_ready=1 the first BUSY cycle and mem_read_data=0xDEADBEEF -> if_gnt in cycle 0, mem_read in cycle 1, if_done with if_rdata=0xDEADBEEF in cycle 2.
REQ-032 Simultaneous if_req and d_req (write 0x55 to 0x20) -> d_gnt first with mem_write=1 and mem_write_data=0x55, then the fetch is granted in the d_done cycle.
REQ-033 With MEM_ARB_RR_EN and both ports requesting continuously for 6 accesses -> grants alternate D,I,D,I,D,I.
REQ-034 TIMEOUT=4 and mem_ready held 0 -> done and bus_err pulse after 4 BUSY cycles, rdata=0, arbiter back in IDLE.
REQ-035 Reset asserted in BUSY_D cycle 2 -> all outputs 0 immediately and no d_done after reset release.
REQ-036 Throughout all tests -> assertion that mem_read&&mem_write is never true and mem_address is stable during BUSY.
